// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: instruction geometry plus the fetch-stage state and entry types.
package riscv_pkg;

    localparam int DEFAULT_XLEN      = 32;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int INSTRUCTION_BYTES = INSTRUCTION_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0]      pc;
        logic [INSTRUCTION_WIDTH-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO with synchronous reset/flush; a push and pop in the same cycle are allowed when full.
module fetch_fifo #(
    parameter type entry_t = logic [63:0],
    parameter int  DEPTH   = 2,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  entry_t           wdata,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // NOTE: storage has no reset; count alone says which slots hold valid data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads the async ROM, buffers words for decode, handles redirects.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int             XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int             FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [XLEN-1:0]              rom_address,
    input  logic [INSTRUCTION_WIDTH-1:0] rom_instruction,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         fetch_valid,
    input  logic                         fetch_ready,
    output logic [INSTRUCTION_WIDTH-1:0] fetch_instruction,
    output logic [XLEN-1:0]              fetch_pc,
    output logic                         fetch_fault
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Same layout as fetch_entry_t, but sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0]              pc;
        logic [INSTRUCTION_WIDTH-1:0] instruction;
    } entry_t;

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    entry_t           tail_entry;
    entry_t           head_entry;

    assign rom_address = pc;
    assign fetch_valid = (count != '0) && !redirect_valid;
    assign pop         = fetch_valid && fetch_ready;
    assign push        = (state == RUN) && !redirect_valid
                         && ((count < CNT_W'(FIFO_DEPTH)) || pop);

    assign tail_entry.pc          = pc;
    assign tail_entry.instruction = rom_instruction;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned  = (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = (state == FAULT);
`else
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];
    assign fetch_fault         = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            state_next = misaligned ? FAULT : RUN;
            pc_next    = redirect_pc;
`else
            state_next = RUN;
            pc_next    = {redirect_pc[XLEN-1:2], 2'b00};
`endif
        end else begin
            if (state == IDLE) begin
                state_next = RUN;
            end
            if (push) begin
                pc_next = pc + XLEN'(INSTRUCTION_BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // A redirect flushes every in-flight fetch; it never pushes in the same cycle.
    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (tail_entry),
        .head  (head_entry),
        .count (count)
    );

    assign fetch_instruction = head_entry.instruction;
    assign fetch_pc          = head_entry.pc;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Sequences the asynchronous-read instruction ROM. Owns the program counter and drives the ROM address.
- Captures each returned word, with its PC, into a small prefetch FIFO and presents it to decode over a valid/ready handshake.
- Accepts redirects (branches/jumps) from execute, which flush all in-flight fetches.
- Sits between the instruction ROM and the decode stage.

Parameters:
- XLEN, 32, address/PC width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FIFO_DEPTH, 2, prefetch entries; power of two, minimum 2

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rom_address  out  XLEN  byte address to ROM; equals pc
- rom_instruction  in  INSTRUCTION_WIDTH  async ROM read data for rom_address, same cycle
- redirect_valid  in  1  load new PC this cycle
- redirect_pc  in  XLEN  redirect target
- fetch_valid  out  1  head entry available to decode
- fetch_ready  in  1  decode accepts head entry
- fetch_instruction  out  INSTRUCTION_WIDTH  head entry instruction
- fetch_pc  out  XLEN  head entry PC
- fetch_fault  out  1  misaligned redirect fault; only with FETCH_MISALIGN_TRAP_EN, otherwise tied 0

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high: sampled on the rising edge of `clk`; no asynchronous reset path.
- Reset values (while rst=1): pc=RESET_PC, state=IDLE, FIFO empty, fetch_valid=0, fetch_fault=0. fetch_instruction and fetch_pc are don't-care while fetch_valid=0.
- FSM states: IDLE, RUN, FAULT.
  - IDLE -> RUN unconditionally on the first edge with rst=0.
  - RUN -> FAULT only under the optional feature.
  - FAULT -> RUN on a redirect with an aligned target.
- A redirect also applies in IDLE: pc loads and the state still moves to RUN.
- rom_address = pc combinationally in all states.
- push = (state==RUN) && !redirect_valid && (count<FIFO_DEPTH || pop).
- On push, {pc, rom_instruction} is written to the tail and pc <= pc + INSTRUCTION_BYTES, modulo 2^XLEN. 32'hFFFF_FFFC wraps to 0.
- pop = fetch_valid && fetch_ready.
- fetch_valid = (count!=0) && !redirect_valid, combinational gate. Decode never consumes in a redirect cycle.
- Simultaneous push and pop when full is allowed: count stays at FIFO_DEPTH. This gives sustained one instruction per cycle.
- Redirect has priority over push and pop. That edge:
  - FIFO flushed to count=0;
  - pc <= redirect_pc;
  - no push.
  - Fetch of the target occurs the next cycle; the target appears at fetch_valid two cycles after the redirect edge.
- Latency:
  - first rst=0 edge: IDLE->RUN;
  - next edge: pushes RESET_PC;
  - following cycle: fetch_valid=1, fetch_pc=RESET_PC.
- Back-pressure: with fetch_ready=0, the FIFO fills to FIFO_DEPTH and the pc stalls at the next unfetched address. No entry is lost or duplicated.
- Low pc bits: without the optional feature, the redirect target is loaded with bits [1:0] forced to 0, so pc stays word-aligned.
- Reset mid-operation: reset overrides everything, including a concurrent redirect. It flushes the FIFO and returns to IDLE on that edge.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined, redirect with redirect_pc[1:0]!=0:
  - state <= FAULT, FIFO flushed, pc <= redirect_pc unmodified;
  - fetch_fault=1 while in FAULT; no pushes in FAULT;
  - fetch_valid=0.
  - An aligned redirect returns to RUN and clears fetch_fault at that edge.
  - A misaligned redirect while in FAULT stays in FAULT.
- Undefined: the FAULT state is unreachable/omitted, fetch_fault is tied 0, and targets are force-aligned as above.

Decomposition:
- riscv_pkg additions:
  - fetch_state_t enum {IDLE, RUN, FAULT};
  - fetch_entry_t struct {pc, instruction}.
- Reuse the existing INSTRUCTION_WIDTH and INSTRUCTION_BYTES from riscv_pkg.
- One sub-module: fetch_fifo.
  - Parameterized on entry type/width and DEPTH.
  - Synchronous reset and flush, push/pop with simultaneous-when-full support.
  - Outputs count, head.

Test Plan:
- Reset release with ROM word0=32'h00500093, word1=32'h00A00113, fetch_ready=1 -> fetch_valid first high on the 2nd cycle after IDLE. Then fetch_pc=0, 4, 8 on consecutive cycles with matching words, one per cycle.
- fetch_ready=0 for 5 cycles from steady state -> count saturates at 2, rom_address frozen at head_pc+8. On release, pcs continue with no gap or duplicate.
- redirect_valid=1, redirect_pc=32'h40 while FIFO holds pcs 8 and 12 -> fetch_valid=0 that cycle. Next valid entry is pc=0x40 two cycles later; 8 and 12 are never accepted.
- RESET_PC=32'hFFFF_FFF8 -> entries FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
- Misaligned redirect to 32'h42:
  - with macro: fetch_fault=1, fetch_valid=0 until a redirect to 32'h80, then pc 0x80 is delivered;
  - without macro: fetch_pc=0x40 is delivered.
- rst asserted for 1 cycle mid-stream, together with a redirect -> next state IDLE, FIFO empty, pc=RESET_PC, and the redirect is ignored.
